display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexes four 5-bit glyph codes onto one shared 7-seg decoder.
//  Drives digit_code into binary_to_segment and the active-low anode enables.
//  Adds per-digit blink, anode dead-time (anti-ghosting) and tear-free
//  frame-synchronous updates via an update/ack handshake.
// PARAMETERS
//  PRESCALE     100000  clk cycles per digit slot (100 MHz -> 1 kHz slot, 250 Hz frame)
//  DEADTIME     8       cycles anodes held all-off at start of each slot; must be < PRESCALE
//  BLINK_FRAMES 125     frames per blink half-period (~1 Hz toggle at defaults)
// PORTS
//  clk          in   1   system clock; sole clock domain
//  reset        in   1   synchronous, active-high reset
//  codes_in     in   20  digit codes; [4:0]=digit0 (rightmost) ... [19:15]=digit3
//  update       in   1   1-cycle strobe: capture codes_in as pending frame data
//  update_ack   out  1   1-cycle pulse when pending data becomes the displayed data
//  blink_mask   in   4   bit n=1: digit n blanks during blink phase 1
//  enable       in   1   0: anodes forced 4'b1111; all counters keep running
//  digit_code   out  5   glyph code to segment decoder (registered)
//  anode        out  4   active-low digit enables, one-hot-low or 4'b1111 (registered)
// BEHAVIOUR
//  Reset: prescaler=0, idx=0, dead counter=DEADTIME, anode=4'b1111, digit_code=5'd18,
//   display regs all 5'd18, pending_valid=0, update_ack=0, blink_phase=0, frame cnt=0.
//  Prescaler counts 0..PRESCALE-1; tick when it is PRESCALE-1, then wraps to 0.
//  On tick: idx <= idx+1 mod 4; dead counter <= DEADTIME. Frame boundary = tick with idx==3.
//  Outputs registered: cycle after tick digit_code = new digit's code, anode=4'b1111.
//  Dead counter decrements to 0; while nonzero anode=4'b1111; at 0 anode=~(4'b1<<idx).
//   DEADTIME=0 -> anode valid the cycle after tick.
//  enable=0 overrides anode to 4'b1111 next cycle; digit_code unaffected.
//  Blink: frame cnt counts boundaries 0..BLINK_FRAMES-1; at wrap blink_phase toggles.
//   digit_code = 5'd18 when blink_phase=1 and blink_mask[idx]=1; else display[idx].
//   blink_mask sampled every cycle (not frame-synchronised).
//  Update handshake:
//   update=1 -> pending <= codes_in, pending_valid <= 1. Repeated updates: last wins,
//    only one ack issued.
//   On frame boundary with pending_valid: display <= pending, pending_valid <= 0,
//    update_ack=1 next cycle. New data first shown for digit0 of the new frame.
//   update coincident with boundary: codes_in bypasses pending straight to display;
//    ack next cycle; pending_valid cleared.
//   No pending at boundary: no ack, display unchanged.
//  Reset mid-frame/mid-update: pending discarded, no ack, all state to reset values.
//  Counter widths: $clog2 of each range; no overflow past terminal counts.
// STRUCTURE
//  Shared package: BLANK_CODE=5'd18, NUM_DIGITS=4, CODE_W=5, ANODE_OFF=4'b1111.
//  Sub-module scan_tick_gen (prescaler -> 1-cycle tick), reused for other timebases.
//  Top holds idx, dead counter, pending/display regs, blink logic, output regs.
// TESTING (PRESCALE=4, DEADTIME=1, BLINK_FRAMES=2)
//  Reset 3 cycles -> anode=4'b1111, digit_code=18, update_ack=0 throughout.
//  update with codes_in={5'd3,5'd2,5'd1,5'd0} mid-frame -> digits stay 18 until boundary;
//   ack pulses once; next frame shows 0,1,2,3 on anodes 1110,1101,1011,0111.
//  Each slot: cycle after tick anode=1111, then one-hot-low; digit_code changes with tick.
//  Two updates in one frame (codes A then B) -> one ack; frame shows B only.
//  update on boundary cycle -> displayed next frame from digit0, ack next cycle, no
//   stale pending.
//  blink_mask=4'b0001 -> digit0 shows 18 in frames 2-3, normal in 0-1 and 4-5;
//   enable=0 -> anode=1111 while idx keeps advancing; reset mid-frame -> clean restart.

Source files
------------

// File: rtl/display_scan_mux_pkg.sv
// Shared constants and helpers for the display scan multiplexer.
//   BLANK_CODE  glyph code the segment decoder renders as an all-off digit
//   NUM_DIGITS  digits sharing the decoder
//   CODE_W      glyph code width
//   ANODE_OFF   active-low anode pattern with every digit disabled
package display_scan_mux_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = 5;
    localparam int IDX_W      = 2;

    localparam logic [CODE_W-1:0]     BLANK_CODE = 5'd18;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = 4'b1111;

    // One code per digit, digit0 in the low slice.
    typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] codes_t;

    // Width of a counter that must hold 0..n-1; never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_scan_mux_scan_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every PERIOD cycles.
//   clk    system clock
//   reset  synchronous active-high reset (counter to 0)
//   tick   high for the single cycle the counter sits at PERIOD-1
module scan_tick_gen
    import display_scan_mux_pkg::*;
#(
    parameter int PERIOD = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = cnt_w(PERIOD);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes four glyph codes onto one shared 7-segment decoder with
// per-digit blink, anode dead-time and frame-synchronous updates.
//   clk, reset   system clock, synchronous active-high reset
//   codes_in     four packed codes, digit0 in [4:0]
//   update       strobe: capture codes_in as pending frame data
//   update_ack   pulse when pending data becomes displayed data
//   blink_mask   per-digit blink enable
//   enable       0 forces every anode off
//   digit_code   registered glyph code for the decoder
//   anode        registered active-low digit enables
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int DEADTIME     = 8,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DIGITS*CODE_W-1:0] codes_in,
    input  logic                         update,
    output logic                         update_ack,
    input  logic [NUM_DIGITS-1:0]        blink_mask,
    input  logic                         enable,
    output logic [CODE_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]        anode
);

    localparam int DEAD_W  = cnt_w(DEADTIME + 1);
    localparam int FRAME_W = cnt_w(BLINK_FRAMES);

    logic               tick, boundary;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [DEAD_W-1:0]  dead, dead_nx;
    logic [FRAME_W-1:0] frame, frame_nx;
    logic               phase, phase_nx;
    codes_t             display, display_nx, pending, pending_nx;
    logic               pend_vld, pend_vld_nx, ack_nx;
    logic [CODE_W-1:0]     code_nx;
    logic [NUM_DIGITS-1:0] anode_nx;

    scan_tick_gen #(.PERIOD(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // Outputs are derived from next-state values so the registered
    // digit_code/anode line up with the slot that starts on this edge.
    always_comb begin
        idx_nx      = tick ? idx + IDX_W'(1) : idx;
        dead_nx     = tick ? DEAD_W'(DEADTIME)
                           : ((dead != '0) ? dead - DEAD_W'(1) : dead);
        frame_nx    = frame;
        phase_nx    = phase;
        display_nx  = display;
        pending_nx  = pending;
        pend_vld_nx = pend_vld;
        ack_nx      = 1'b0;

        if (boundary) begin
            if (frame == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_nx = '0;
                phase_nx = ~phase;
            end else begin
                frame_nx = frame + FRAME_W'(1);
            end
            // An update landing on the boundary skips the pending stage so
            // it is not held back a whole frame.
            if (update) begin
                display_nx = codes_in;
                ack_nx     = 1'b1;
            end else if (pend_vld) begin
                display_nx = pending;
                ack_nx     = 1'b1;
            end
            pend_vld_nx = 1'b0;
        end else if (update) begin
            pending_nx  = codes_in;
            pend_vld_nx = 1'b1;
        end

        code_nx  = (phase_nx && blink_mask[idx_nx]) ? BLANK_CODE : display_nx[idx_nx];
        anode_nx = (!enable || dead_nx != '0) ? ANODE_OFF
                                              : ~(NUM_DIGITS'(1) << idx_nx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            dead       <= DEAD_W'(DEADTIME);
            frame      <= '0;
            phase      <= 1'b0;
            display    <= {NUM_DIGITS{BLANK_CODE}};
            pending    <= {NUM_DIGITS{BLANK_CODE}};
            pend_vld   <= 1'b0;
            update_ack <= 1'b0;
            digit_code <= BLANK_CODE;
            anode      <= ANODE_OFF;
        end else begin
            idx        <= idx_nx;
            dead       <= dead_nx;
            frame      <= frame_nx;
            phase      <= phase_nx;
            display    <= display_nx;
            pending    <= pending_nx;
            pend_vld   <= pend_vld_nx;
            update_ack <= ack_nx;
            digit_code <= code_nx;
            anode      <= anode_nx;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] codes_in = '0;
    logic        update = 1'b0;
    logic        update_ack;
    logic [3:0]  blink_mask = '0;
    logic        enable = 1'b1;
    logic [4:0]  digit_code;
    logic [3:0]  anode;

    display_scan_mux #(.PRESCALE(4), .DEADTIME(1), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .codes_in   (codes_in),
        .update     (update),
        .update_ack (update_ack),
        .blink_mask (blink_mask),
        .enable     (enable),
        .digit_code (digit_code),
        .anode      (anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [4:0] code;
        logic       ack;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        upd;
        logic [19:0] codes;
        logic [3:0]  mask;
        logic        en;
        logic [3:0]  e_an;
        logic [4:0]  e_code;
        logic        e_ack;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[23];
    int   checks = 0;
    int   errors = 0;

    // Reference model: slot timing in closed form from edges since reset.
    int         n;
    logic [4:0] m_disp[4];
    logic [4:0] m_pend[4];
    logic       m_pv;

    task automatic model_reset();
        n    = 0;
        m_pv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_disp[i] = 5'd18;
            m_pend[i] = 5'd18;
        end
    endtask

    task automatic step(input logic rst, input logic upd, input logic [19:0] c,
                        input logic [3:0] m, input logic e);
        exp_t x;
        exp_t got;
        int   idx, f;
        logic bnd, phase;
        @(negedge clk);
        reset = rst; update = upd; codes_in = c; blink_mask = m; enable = e;
        if (rst) begin
            model_reset();
            x.an = 4'b1111; x.code = 5'd18; x.ack = 1'b0;
        end else begin
            n++;
            bnd   = (n % 16 == 0);
            x.ack = bnd && (m_pv || upd);
            if (bnd) begin
                if (upd) for (int i = 0; i < 4; i++) m_disp[i] = c[i*5 +: 5];
                else if (m_pv) for (int i = 0; i < 4; i++) m_disp[i] = m_pend[i];
                m_pv = 1'b0;
            end else if (upd) begin
                for (int i = 0; i < 4; i++) m_pend[i] = c[i*5 +: 5];
                m_pv = 1'b1;
            end
            idx    = (n / 4) % 4;
            f      = n / 16;
            phase  = ((f / 2) % 2) == 1;
            x.code = (phase && m[idx]) ? 5'd18 : m_disp[idx];
            x.an   = (!e || (n % 4 == 0)) ? 4'b1111 : ~(4'b0001 << idx);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (anode !== got.an || digit_code !== got.code || update_ack !== got.ack) begin
            errors++;
            $display("FAIL scoreboard n=%0d: got anode=%b code=%0d ack=%b, want anode=%b code=%0d ack=%b",
                     n, anode, digit_code, update_ack, got.an, got.code, got.ack);
        end
    endtask

    task automatic hand_check(input string name, input logic [3:0] an,
                              input logic [4:0] code, input logic ack);
        checks++;
        if (anode !== an || digit_code !== code || update_ack !== ack) begin
            errors++;
            $display("FAIL %s: got anode=%b code=%0d ack=%b, want anode=%b code=%0d ack=%b",
                     name, anode, digit_code, update_ack, an, code, ack);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] ca, cb1, cb2, cc, cd;
        ca  = {5'd3, 5'd2, 5'd1, 5'd0};
        cb1 = {5'd7, 5'd6, 5'd5, 5'd4};
        cb2 = {5'd11, 5'd10, 5'd9, 5'd8};
        cc  = {5'd15, 5'd14, 5'd13, 5'd12};
        cd  = {5'd1, 5'd1, 5'd1, 5'd1};

        //           cyc upd codes mask  en  anode    code  ack
        tbl[0]  = '{  5, 0, ca,  4'h0, 1, 4'b1101, 5'd18, 0};
        tbl[1]  = '{  1, 1, ca,  4'h0, 1, 4'b1101, 5'd18, 0};
        tbl[2]  = '{ 10, 0, ca,  4'h0, 1, 4'b1111, 5'd0,  1};
        tbl[3]  = '{  1, 0, ca,  4'h0, 1, 4'b1110, 5'd0,  0};
        tbl[4]  = '{  4, 0, ca,  4'h0, 1, 4'b1101, 5'd1,  0};
        tbl[5]  = '{  4, 0, ca,  4'h0, 1, 4'b1011, 5'd2,  0};
        tbl[6]  = '{  4, 0, ca,  4'h0, 1, 4'b0111, 5'd3,  0};
        tbl[7]  = '{  3, 0, ca,  4'h0, 1, 4'b1111, 5'd0,  0};
        tbl[8]  = '{  1, 1, cb1, 4'h0, 1, 4'b1110, 5'd0,  0};
        tbl[9]  = '{  1, 1, cb2, 4'h0, 1, 4'b1110, 5'd0,  0};
        tbl[10] = '{ 14, 0, cb2, 4'h0, 1, 4'b1111, 5'd8,  1};
        tbl[11] = '{  1, 0, cb2, 4'h0, 1, 4'b1110, 5'd8,  0};
        tbl[12] = '{  4, 0, cb2, 4'h0, 1, 4'b1101, 5'd9,  0};
        tbl[13] = '{ 10, 0, cb2, 4'h0, 1, 4'b0111, 5'd11, 0};
        tbl[14] = '{  1, 1, cc,  4'h0, 1, 4'b1111, 5'd12, 1};
        tbl[15] = '{  1, 0, cc,  4'h0, 1, 4'b1110, 5'd12, 0};
        tbl[16] = '{ 15, 0, cc,  4'h0, 1, 4'b1111, 5'd12, 0};
        tbl[17] = '{ 17, 0, cc,  4'h1, 1, 4'b1110, 5'd18, 0};
        tbl[18] = '{  4, 0, cc,  4'h1, 1, 4'b1101, 5'd13, 0};
        tbl[19] = '{ 28, 0, cc,  4'h1, 1, 4'b1110, 5'd12, 0};
        tbl[20] = '{  8, 0, cc,  4'h0, 0, 4'b1111, 5'd14, 0};
        tbl[21] = '{  1, 0, cc,  4'h0, 1, 4'b1011, 5'd14, 0};
        tbl[22] = '{  1, 1, cd,  4'h0, 1, 4'b1011, 5'd14, 0};

        model_reset();
        // Power-on reset: outputs idle every reset cycle.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, '0, 4'h0, 1'b1);
            hand_check("reset_idle", 4'b1111, 5'd18, 1'b0);
        end

        for (int r = 0; r < 23; r++) begin
            for (int k = 0; k < tbl[r].cyc; k++)
                step(1'b0, tbl[r].upd && (k == 0), tbl[r].codes, tbl[r].mask, tbl[r].en);
            hand_check($sformatf("vec%0d", r), tbl[r].e_an, tbl[r].e_code, tbl[r].e_ack);
        end

        // Reset with an update pending mid-frame: pending data must be dropped.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, cd, 4'h0, 1'b1);
            hand_check("midreset_idle", 4'b1111, 5'd18, 1'b0);
        end
        for (int k = 0; k < 16; k++)
            step(1'b0, 1'b0, cd, 4'h0, 1'b1);
        hand_check("midreset_no_ack", 4'b1111, 5'd18, 1'b0);
        step(1'b0, 1'b0, cd, 4'h0, 1'b1);
        hand_check("midreset_digit0", 4'b1110, 5'd18, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
